// File: rtl/chip_drop_ctrl.sv
// Connect-four chip drop controller: validates a column, draws the chip cell
// for 256 cycles, then records the chip and hands the turn to the other player.
module chip_drop_ctrl #(
  parameter logic [7:0] X_ORIGIN = 8'd24,
  parameter logic [6:0] Y_ORIGIN = 7'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drop,
  input  logic [2:0] col_sel,
  output logic [7:0] xout,
  output logic [6:0] yout,
  output logic       draw_red,
  output logic       draw_blue,
  output logic       busy,
  output logic       done,
  output logic       invalid,
  output logic       player,
  output logic [6:0] col_full,
  output logic       board_full
);

  localparam int unsigned NCOL   = 7;
  localparam int unsigned NROW   = 6;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CELL_W = 4;

  typedef enum logic [1:0] {IDLE, CHECK, DRAW, DONE} state_t;

  state_t             state;
  logic [2:0]         col;
  logic [2:0]         height [NCOL];
  logic [CNT_W-1:0]   cnt;

  logic [2:0]         sel_height_c;
  logic               sel_bad_c;
  logic [2:0]         col_height_c;
  logic [2:0]         row_c;

  // Height lookups guarded so an out-of-range column never indexes the array
  always_comb begin
    sel_height_c = '0;
    col_height_c = '0;
    if (col_sel < 3'(NCOL)) sel_height_c = height[col_sel];
    if (col < 3'(NCOL))     col_height_c = height[col];
    sel_bad_c = (col_sel > 3'(NCOL - 1)) || (sel_height_c == 3'(NROW));
    row_c     = 3'(NROW - 1) - col_height_c;
  end

  for (genvar c = 0; c < NCOL; c++) begin : g_full
    assign col_full[c] = (height[c] == 3'(NROW));
  end
  assign board_full = &col_full;

  // Control FSM; the validity verdict is registered on entry so invalid is high during CHECK
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      for (int i = 0; i < NCOL; i++) height[i] <= '0;
      player    <= 1'b0;
      cnt       <= '0;
      xout      <= '0;
      yout      <= '0;
      draw_red  <= 1'b0;
      draw_blue <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done    <= 1'b0;
      invalid <= 1'b0;
      case (state)
        IDLE: begin
          if (drop) begin
            col     <= col_sel;
            invalid <= sel_bad_c;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (invalid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            xout  <= X_ORIGIN + 8'({col, CELL_W'(0)});
            yout  <= Y_ORIGIN + 7'({row_c, CELL_W'(0)});
            cnt   <= '0;
            state <= DRAW;
          end
        end
        DRAW: begin
          // First DRAW cycle arms the enable; the counter then runs 0..255 under it
          if (!draw_red && !draw_blue) begin
            draw_red  <= ~player;
            draw_blue <= player;
          end else if (cnt == CNT_W'(255)) begin
            draw_red  <= 1'b0;
            draw_blue <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          height[col] <= height[col] + 3'd1;
          player      <= ~player;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_drop_ctrl.sv
// Directed bench for chip_drop_ctrl: vector table of drops plus reset,
// ignored-drop and board-full sequences.
module tb_chip_drop_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       drop;
  logic [2:0] col_sel;
  logic [7:0] xout;
  logic [6:0] yout;
  logic       draw_red, draw_blue, busy, done, invalid, player;
  logic [6:0] col_full;
  logic       board_full;

  int total = 0;
  int bad   = 0;

  chip_drop_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .drop       (drop),
    .col_sel    (col_sel),
    .xout       (xout),
    .yout       (yout),
    .draw_red   (draw_red),
    .draw_blue  (draw_blue),
    .busy       (busy),
    .done       (done),
    .invalid    (invalid),
    .player     (player),
    .col_full   (col_full),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] col;
    logic       ok;
    logic [7:0] x;
    logic [6:0] y;
    logic       pl;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drop  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drop one chip and watch every cycle until the FSM is back in IDLE.
  // k counts cycles sampled after the edge that takes the drop.
  task automatic run_drop(input logic [2:0] c, input logic ok, input logic [7:0] ex,
                          input logic [6:0] ey, input logic pl, input logic noise);
    int en_cnt, first_en, last_en, done_cnt, done_k, xy_bad, wrong_en, busy_end;
    en_cnt = 0; first_en = -1; last_en = -1; done_cnt = 0; done_k = -1;
    xy_bad = 0; wrong_en = 0; busy_end = 1;
    chk("player_before", 32'(player), 32'(pl));
    @(negedge clk);
    drop    = 1'b1;
    col_sel = c;
    @(posedge clk);
    @(negedge clk);
    drop = 1'b0;
    chk("busy_in_check", 32'(busy), 32'd1);
    chk("invalid_in_check", 32'(invalid), 32'(!ok));
    if (!ok) begin
      @(negedge clk);
      chk("busy_after_reject", 32'(busy), 32'd0);
      chk("invalid_pulse_len", 32'(invalid), 32'd0);
      chk("no_enable_reject", 32'({draw_red, draw_blue}), 32'd0);
      chk("player_after_reject", 32'(player), 32'(pl));
    end else begin
      for (int k = 1; k <= 260; k++) begin
        @(negedge clk);
        if (noise) begin
          drop    = (k == 100 || k == 258);
          col_sel = 3'd0;
        end
        if (draw_red || draw_blue) begin
          en_cnt++;
          if (first_en < 0) first_en = k;
          last_en = k;
          if (xout !== ex || yout !== ey) xy_bad++;
          if (draw_red !== !pl || draw_blue !== pl) wrong_en++;
        end
        if (done) begin
          done_cnt++;
          done_k = k;
        end
        if (k == 260) busy_end = busy;
      end
      drop = 1'b0;
      chk("enable_cycles", 32'(en_cnt), 32'd256);
      chk("enable_first", 32'(first_en), 32'd2);
      chk("enable_last", 32'(last_en), 32'd257);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_k), 32'd258);
      chk("xy_during_draw", 32'(xy_bad), 32'd0);
      chk("enable_colour", 32'(wrong_en), 32'd0);
      chk("xout", 32'(xout), 32'(ex));
      chk("yout", 32'(yout), 32'(ey));
      chk("busy_after_done", 32'(busy_end), 32'd0);
      chk("player_after", 32'(player), 32'(!pl));
    end
  endtask

  initial begin
    reset   = 1'b0;
    drop    = 1'b0;
    col_sel = 3'd0;

    tbl[0]  = '{3'd3, 1'b1, 8'd72,  7'd96, 1'b0};
    tbl[1]  = '{3'd3, 1'b1, 8'd72,  7'd80, 1'b1};
    tbl[2]  = '{3'd7, 1'b0, 8'd0,   7'd0,  1'b0};
    tbl[3]  = '{3'd0, 1'b1, 8'd24,  7'd96, 1'b0};
    tbl[4]  = '{3'd0, 1'b1, 8'd24,  7'd80, 1'b1};
    tbl[5]  = '{3'd0, 1'b1, 8'd24,  7'd64, 1'b0};
    tbl[6]  = '{3'd0, 1'b1, 8'd24,  7'd48, 1'b1};
    tbl[7]  = '{3'd0, 1'b1, 8'd24,  7'd32, 1'b0};
    tbl[8]  = '{3'd0, 1'b1, 8'd24,  7'd16, 1'b1};
    tbl[9]  = '{3'd0, 1'b0, 8'd0,   7'd0,  1'b0};
    tbl[10] = '{3'd6, 1'b1, 8'd120, 7'd96, 1'b0};

    do_reset();
    chk("rst_xout", 32'(xout), 32'd0);
    chk("rst_yout", 32'(yout), 32'd0);
    chk("rst_enables", 32'({draw_red, draw_blue}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_invalid", 32'({done, invalid}), 32'd0);
    chk("rst_player", 32'(player), 32'd0);
    chk("rst_col_full", 32'(col_full), 32'd0);
    chk("rst_board_full", 32'(board_full), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_drop(tbl[i].col, tbl[i].ok, tbl[i].x, tbl[i].y, tbl[i].pl, 1'b0);
      if (i == 8) chk("col0_full", 32'(col_full), 32'h01);
    end
    chk("col_full_after_table", 32'(col_full), 32'h01);

    // Drops during DRAW and DONE are ignored: col 3 third chip lands in row 2
    run_drop(3'd3, 1'b1, 8'd72, 7'd64, 1'b1, 1'b1);
    @(negedge clk);
    chk("noise_no_new_busy", 32'(busy), 32'd0);
    run_drop(3'd3, 1'b1, 8'd72, 7'd48, 1'b0, 1'b0);

    // Reset in the middle of a draw
    do_reset();
    @(negedge clk);
    drop    = 1'b1;
    col_sel = 3'd2;
    @(posedge clk);
    @(negedge clk);
    drop = 1'b0;
    repeat (101) @(negedge clk);
    chk("pre_reset_red", 32'(draw_red), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_enables", 32'({draw_red, draw_blue}), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_player", 32'(player), 32'd0);
    chk("midreset_xy", 32'({xout, yout}), 32'd0);
    chk("midreset_col_full", 32'(col_full), 32'd0);
    run_drop(3'd2, 1'b1, 8'd56, 7'd96, 1'b0, 1'b0);

    // Fill the whole board, then a drop must be rejected
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        run_drop(3'(c), 1'b1, 8'(24 + 16 * c), 7'(16 + 16 * (5 - r)), 1'((c * 6 + r) % 2), 1'b0);
      end
      chk("fill_col_full", 32'(col_full), 32'((1 << (c + 1)) - 1));
      if (c == 5) chk("not_yet_board_full", 32'(board_full), 32'd0);
    end
    chk("board_full", 32'(board_full), 32'd1);
    run_drop(3'd4, 1'b0, 8'd0, 7'd0, 1'b0, 1'b0);
    chk("board_full_kept", 32'(board_full), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
